data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words in the array.
REQ-002 Parameter LATENCY, default 2, legal range 0..15: number of wait cycles between request accept and response.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low; Rst=0 resets, Rst=1 runs.
REQ-005 ReqValid  input  1  requester has a memory access pending.
REQ-006 ReqWrite  input  1  1=store, 0=load.
REQ-007 ReqAddr  input  32  byte address.
REQ-008 ReqWData  input  32  store data, right-aligned.
REQ-009 ReqSize  input  2  00=byte, 01=half, 10=word, 11=reserved.
REQ-010 ReqSigned  input  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-011 ReqReady  output  1  responder can accept a request this cycle.
REQ-012 RespValid  output  1  one-cycle pulse: response for the accepted request.
REQ-013 RespRData  output  32  load result, extended to 32 bits.
REQ-014 RespErr  output  1  request was misaligned or used reserved size; valid with RespValid.

Function
REQ-015 States IDLE, WAIT, RESP; ReqReady=1 only in IDLE.
REQ-016 Handshake: request accepted on a rising edge with ReqValid=1 and ReqReady=1; all Req* fields latched on that edge; Req* ignored in other states.
REQ-017 IDLE -> WAIT on accept when LATENCY>0; IDLE -> RESP on accept when LATENCY=0.
REQ-018 WAIT: 4-bit counter loaded with LATENCY-1 on accept, decrements each cycle; WAIT -> RESP on the cycle it reads 0.
REQ-019 Array access (read or write) executes on the edge entering RESP, using latched fields; total accept-to-RespValid latency = LATENCY+1 cycles.
REQ-020 RESP lasts exactly one cycle with RespValid=1, then -> IDLE; a new request is accepted earliest the cycle after RESP.
REQ-021 Word index = ReqAddr[31:2] modulo DEPTH (wrap-around, no out-of-range error).
REQ-022 Misaligned: half with addr[0]=1, word with addr[1:0]!=00, or ReqSize=11 -> RespErr=1, RespRData=0, no array write.
REQ-023 Byte load: lane addr[1:0] (lane 0 = bits 7:0), extended per ReqSigned; half load: lane addr[1] (0 = bits 15:0), extended per ReqSigned; word load: full word.
REQ-024 Byte/half store: only the addressed lane(s) modified, other bytes of the word preserved; word store replaces the word.
REQ-025 Store response: RespValid=1, RespRData=0, RespErr per REQ-022.
REQ-026 Outside RESP, RespValid=0, RespErr=0, RespRData=0.

Reset
REQ-027 Rst=0 forces state IDLE, counter 0, latched request cleared, ReqReady=1 once Rst=1, RespValid=0, RespRData=0, RespErr=0, asynchronously.
REQ-028 Reset in WAIT abandons the request: no array write, no RespValid.
REQ-029 Array contents are not reset; unwritten words read as undefined.

Structure
REQ-030 Shared package mem_pkg holds the ReqSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encoding (IDLE, WAIT, RESP).
REQ-031 One sub-module, mem_align: combinational lane select/extension for loads, lane merge for stores, and misalignment detection.
REQ-032 The array is a single synchronous-write register array inside data_mem_resp.

Verification
REQ-033 LATENCY=2: word store 0xDEADBEEF to 0x40, then word load 0x40 -> each RespValid exactly 3 cycles after accept; load RespRData=0xDEADBEEF, RespErr=0.
REQ-034 After REQ-033: byte load 0x43 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; half load 0x40 signed -> 0xFFFFBEEF.
REQ-035 Byte store 0x12 to 0x41, then word load 0x40 -> 0xDEAD12EF.
REQ-036 Word load from 0x42 -> RespErr=1, RespRData=0; word store to 0x41 -> RespErr=1 and subsequent load 0x40 unchanged.
REQ-037 DEPTH=1024: word store 0x5 to 0x1000, load 0x0 -> 0x00000005 (wrap); ReqValid held high continuously -> ReqReady low in WAIT/RESP, only one request accepted per transaction.
REQ-038 Store to 0x80 with Rst=0 pulsed during WAIT -> no RespValid, load 0x80 afterwards returns prior contents; LATENCY=0 -> RespValid 1 cycle after accept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data_mem_resp responder: access sizes, FSM states
// and the load extension helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic [31:0] extend8(input logic [7:0] v, input logic sx);
        return {{24{sx & v[7]}}, v};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] v, input logic sx);
        return {{16{sx & v[15]}}, v};
    endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bus between a load/store requester and data_mem_resp.
interface data_mem_resp_if;
    logic        ReqValid;
    logic        ReqWrite;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic        ReqReady;
    logic        RespValid;
    logic [31:0] RespRData;
    logic        RespErr;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqSize, ReqSigned,
        input  ReqReady, RespValid, RespRData, RespErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqSize, ReqSigned,
        output ReqReady, RespValid, RespRData, RespErr
    );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: load lane select/extension, store lane merge into
// the existing word, and misalignment / reserved-size detection.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic        misaligned,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    // Lane select and merge per access size; untouched lanes keep old_word
    always_comb begin
        misaligned = 1'b0;
        load_data  = 32'd0;
        store_word = old_word;
        case (size_e'(size))
            SZ_BYTE: begin
                load_data = extend8(old_word[{addr_lo, 3'b000} +: 8], sign_ext);
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                if (addr_lo[0]) begin
                    misaligned = 1'b1;
                end else begin
                    load_data = extend16(old_word[{addr_lo[1], 4'b0000} +: 16], sign_ext);
                    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                end
            end
            SZ_WORD: begin
                if (addr_lo != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    load_data  = old_word;
                    store_word = wdata;
                end
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_resp.sv
// Single-outstanding data memory responder: accepts one load/store, waits
// LATENCY cycles, performs the array access and returns a one-cycle response.
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    data_mem_resp_if.slave   bus
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         ZERO_LAT = (LATENCY == 0);

    state_e      state_r, state_s;
    logic [3:0]  cnt_r;
    logic        wr_r, sg_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r;

    logic        accept_s, enter_resp_s;
    logic        cur_wr_s, cur_sg_s;
    logic [1:0]  cur_size_s;
    logic [31:0] cur_addr_s, cur_wdata_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0] old_word_s, load_s, store_s;
    logic        misaligned_s;

    logic        resp_valid_r, resp_err_r;
    logic [31:0] resp_rdata_r;

    logic [31:0] mem_r [DEPTH];

    assign accept_s = (state_r == IDLE) & bus.ReqValid;

    // With LATENCY=0 the access happens on the accept edge itself, so the
    // live bus fields stand in for the not-yet-latched copy while in IDLE.
    assign cur_wr_s    = (state_r == IDLE) ? bus.ReqWrite  : wr_r;
    assign cur_sg_s    = (state_r == IDLE) ? bus.ReqSigned : sg_r;
    assign cur_size_s  = (state_r == IDLE) ? bus.ReqSize   : size_r;
    assign cur_addr_s  = (state_r == IDLE) ? bus.ReqAddr   : addr_r;
    assign cur_wdata_s = (state_r == IDLE) ? bus.ReqWData  : wdata_r;

    assign idx_s      = IDX_W'(cur_addr_s[31:2] % 30'(DEPTH));
    assign old_word_s = mem_r[idx_s];

    mem_align u_align (
        .addr_lo    (cur_addr_s[1:0]),
        .size       (cur_size_s),
        .sign_ext   (cur_sg_s),
        .wdata      (cur_wdata_s),
        .old_word   (old_word_s),
        .misaligned (misaligned_s),
        .load_data  (load_s),
        .store_word (store_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.ReqValid) begin
                    state_s = ZERO_LAT ? RESP : WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    assign enter_resp_s = (state_s == RESP);

    // State, wait counter, latched request and registered response
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            wr_r         <= 1'b0;
            sg_r         <= 1'b0;
            size_r       <= 2'b00;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                wr_r    <= bus.ReqWrite;
                sg_r    <= bus.ReqSigned;
                size_r  <= bus.ReqSize;
                addr_r  <= bus.ReqAddr;
                wdata_r <= bus.ReqWData;
                cnt_r   <= CNT_LOAD;
            end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            resp_valid_r <= enter_resp_s;
            resp_err_r   <= enter_resp_s & misaligned_s;
            resp_rdata_r <= (enter_resp_s & ~cur_wr_s & ~misaligned_s) ? load_s : 32'd0;
        end
    end

    // Array write on the edge entering RESP; contents are never reset
    always_ff @(posedge Clk) begin
        if (Rst & enter_resp_s & cur_wr_s & ~misaligned_s) begin
            mem_r[idx_s] <= store_s;
        end
    end

    assign bus.ReqReady  = (state_r == IDLE);
    assign bus.RespValid = resp_valid_r;
    assign bus.RespErr   = resp_err_r;
    assign bus.RespRData = resp_rdata_r;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench: two responders (LATENCY 2 and 0) checked against a
// word-array reference model with directed and random load/store traffic.
module tb_data_mem_resp;

    localparam int DEPTH = 1024;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic Clk;
    logic Rst_a, Rst_b;
    logic en_b;
    logic req_valid, req_write, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    int checks;
    int errors;

    logic [31:0] mem_model [int];

    data_mem_resp_if bus_a ();
    data_mem_resp_if bus_b ();

    assign bus_a.ReqValid  = req_valid;
    assign bus_a.ReqWrite  = req_write;
    assign bus_a.ReqAddr   = req_addr;
    assign bus_a.ReqWData  = req_wdata;
    assign bus_a.ReqSize   = req_size;
    assign bus_a.ReqSigned = req_signed;
    assign bus_b.ReqValid  = req_valid & en_b;
    assign bus_b.ReqWrite  = req_write;
    assign bus_b.ReqAddr   = req_addr;
    assign bus_b.ReqWData  = req_wdata;
    assign bus_b.ReqSize   = req_size;
    assign bus_b.ReqSigned = req_signed;

    data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (.Clk(Clk), .Rst(Rst_a), .bus(bus_a));
    data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (.Clk(Clk), .Rst(Rst_b), .bus(bus_b));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic bit mdl_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input bit sg);
        longint v;
        int sh;
        sh = 8 * int'(a % 4);
        case (sz)
            2'd0: begin
                v = longint'((w >> sh) % 256);
                if (sg && v >= 128) v -= 256;
            end
            2'd1: begin
                v = longint'((w >> sh) % 65536);
                if (sg && v >= 32768) v -= 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        sh = 8 * int'(a % 4);
        case (sz)
            2'd0: mask = 32'h0000_00FF << sh;
            2'd1: mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input bit sg, input bit hold,
                       output logic [31:0] rd_out);
        int idx;
        bit exp_err, known, got_a, got_b;
        int lat_a, lat_b;
        logic [31:0] exp_rd, rd_a, rd_b;
        logic er_a, er_b;
        idx     = int'((addr >> 2) % DEPTH);
        exp_err = mdl_err(addr, sz);
        known   = mem_model.exists(idx);
        exp_rd  = (wr || exp_err || !known) ? 32'd0 : mdl_load(mem_model[idx], addr, sz, sg);
        got_a = 1'b0; got_b = 1'b0; lat_a = 0; lat_b = 0;
        rd_a = 32'd0; rd_b = 32'd0; er_a = 1'b0; er_b = 1'b0;

        @(negedge Clk);
        req_write = wr; req_addr = addr; req_wdata = wd; req_size = sz; req_signed = sg;
        req_valid = 1'b1;
        check_eq("ready_a", 64'(bus_a.ReqReady), 64'd1);
        if (en_b) check_eq("ready_b", 64'(bus_b.ReqReady), 64'd1);
        @(posedge Clk);
        for (int n = 1; n <= 6; n++) begin
            @(negedge Clk);
            if (n == 1 && !hold) req_valid = 1'b0;
            if (bus_a.RespValid) begin
                if (!got_a) begin
                    got_a = 1'b1; lat_a = n; rd_a = bus_a.RespRData; er_a = bus_a.RespErr;
                end else begin
                    check_eq("pulse_a", 64'd1, 64'd0);
                end
            end else begin
                check_eq("quiet_a", {31'd0, bus_a.RespErr, bus_a.RespRData}, 64'd0);
                if (hold && !got_a) check_eq("busy_a", 64'(bus_a.ReqReady), 64'd0);
            end
            if (en_b && bus_b.RespValid) begin
                if (!got_b) begin
                    got_b = 1'b1; lat_b = n; rd_b = bus_b.RespRData; er_b = bus_b.RespErr;
                end else begin
                    check_eq("pulse_b", 64'd1, 64'd0);
                end
            end
            if (hold && got_a) req_valid = 1'b0;
        end
        req_valid = 1'b0;

        check_eq("lat_a", 64'(lat_a), 64'(LAT_A + 1));
        check_eq("err_a", 64'(er_a), 64'(exp_err));
        if (wr || exp_err || known) check_eq("rdata_a", 64'(rd_a), 64'(exp_rd));
        if (en_b) begin
            check_eq("lat_b", 64'(lat_b), 64'(LAT_B + 1));
            check_eq("err_b", 64'(er_b), 64'(exp_err));
            if (wr || exp_err || known) check_eq("rdata_b", 64'(rd_b), 64'(exp_rd));
        end
        if (wr && !exp_err) begin
            mem_model[idx] = mdl_store(known ? mem_model[idx] : 32'd0, addr, wd, sz);
        end
        rd_out = rd_a;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        checks = 0; errors = 0;
        en_b = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_size = 2'd0;
        Rst_a = 1'b0; Rst_b = 1'b0;

        repeat (2) @(negedge Clk);
        check_eq("rst_resp_a", {31'd0, bus_a.RespValid, 1'b0, bus_a.RespErr, bus_a.RespRData[29:0]}, 64'd0);
        check_eq("rst_rdata_a", 64'(bus_a.RespRData), 64'd0);
        Rst_a = 1'b1; Rst_b = 1'b1;
        @(negedge Clk);
        check_eq("rst_ready_a", 64'(bus_a.ReqReady), 64'd1);
        check_eq("rst_ready_b", 64'(bus_b.ReqReady), 64'd1);

        // Fill the working window so later partial accesses have defined data
        for (int w = 0; w <= 33; w++) begin
            txn(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 1'b0, rd);
        end

        txn(1'b1, 32'h40, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, rd);
        txn(1'b0, 32'h40, 32'd0, 2'd2, 1'b0, 1'b0, rd);
        check_eq("word_ld", 64'(rd), 64'hDEAD_BEEF);
        txn(1'b0, 32'h43, 32'd0, 2'd0, 1'b1, 1'b0, rd);
        check_eq("byte_s", 64'(rd), 64'hFFFF_FFDE);
        txn(1'b0, 32'h43, 32'd0, 2'd0, 1'b0, 1'b0, rd);
        check_eq("byte_u", 64'(rd), 64'h0000_00DE);
        txn(1'b0, 32'h40, 32'd0, 2'd1, 1'b1, 1'b0, rd);
        check_eq("half_s", 64'(rd), 64'hFFFF_BEEF);
        txn(1'b1, 32'h41, 32'h0000_0012, 2'd0, 1'b0, 1'b0, rd);
        txn(1'b0, 32'h40, 32'd0, 2'd2, 1'b0, 1'b0, rd);
        check_eq("byte_merge", 64'(rd), 64'hDEAD_12EF);
        txn(1'b0, 32'h42, 32'd0, 2'd2, 1'b0, 1'b0, rd);
        txn(1'b1, 32'h41, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b0, rd);
        txn(1'b0, 32'h40, 32'd0, 2'd2, 1'b0, 1'b0, rd);
        check_eq("mis_st_kept", 64'(rd), 64'hDEAD_12EF);
        txn(1'b1, 32'h1000, 32'h0000_0005, 2'd2, 1'b0, 1'b0, rd);
        txn(1'b0, 32'h0, 32'd0, 2'd2, 1'b0, 1'b0, rd);
        check_eq("wrap", 64'(rd), 64'h0000_0005);

        en_b = 1'b0;
        txn(1'b0, 32'h40, 32'd0, 2'd2, 1'b0, 1'b1, rd);
        check_eq("hold_ld", 64'(rd), 64'hDEAD_12EF);

        // Reset pulse while dut_a sits in WAIT abandons the store
        @(negedge Clk);
        req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'hA5A5_5A5A;
        req_size = 2'd2; req_signed = 1'b0; req_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        Rst_a = 1'b0;
        #2;
        check_eq("rst_wait_valid", 64'(bus_a.RespValid), 64'd0);
        #1;
        Rst_a = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge Clk);
            check_eq("rst_noresp", 64'(bus_a.RespValid), 64'd0);
        end
        check_eq("rst_ready", 64'(bus_a.ReqReady), 64'd1);
        en_b = 1'b1;
        txn(1'b0, 32'h80, 32'd0, 2'd2, 1'b0, 1'b0, rd);

        for (int i = 0; i < 150; i++) begin
            a = 32'($urandom_range(0, 33) * 4 + $urandom_range(0, 3) + $urandom_range(0, 3) * 32'h1000);
            txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b0, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
